// File: rtl/cdb_arbiter.sv
// Result arbiter: per-FU result FIFOs feed NUM_CDB registered common data buses
// through a multi-grant round-robin scheduler; a mispredict flush drops everything.
module cdb_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int NUM_CDB    = 2,
    parameter int CDB_WIDTH  = 16,
    parameter int FIFO_DEPTH = 2,
    parameter int SRC_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                                clk_i,
    input  logic                                reset_i,
    input  logic [NUM_REQ-1:0]                  req_valid_i,
    input  logic [NUM_REQ-1:0][CDB_WIDTH-1:0]   req_data_i,
    output logic [NUM_REQ-1:0]                  req_ready_o,
    input  logic                                flush_i,
    output logic [NUM_CDB-1:0]                  cdb_valid_o,
    output logic [NUM_CDB-1:0][CDB_WIDTH-1:0]   cdb_data_o,
    output logic [NUM_CDB-1:0][SRC_W-1:0]       cdb_src_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [NUM_REQ-1:0]                 full;
    logic [NUM_REQ-1:0]                 empty;
    logic [NUM_REQ-1:0]                 grant;
    logic [NUM_REQ-1:0][CDB_WIDTH-1:0]  head_data;

    logic [SRC_W-1:0]                   rr_ptr_reg;
    logic [SRC_W-1:0]                   rr_ptr_next;
    logic [NUM_CDB-1:0]                 bus_valid_reg;
    logic [NUM_CDB-1:0]                 bus_valid_next;
    logic [NUM_CDB-1:0][CDB_WIDTH-1:0]  bus_data_reg;
    logic [NUM_CDB-1:0][CDB_WIDTH-1:0]  bus_data_next;
    logic [NUM_CDB-1:0][SRC_W-1:0]      bus_src_reg;
    logic [NUM_CDB-1:0][SRC_W-1:0]      bus_src_next;
    int                                 grant_cnt;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_fifo
            logic [CDB_WIDTH-1:0] mem_reg [FIFO_DEPTH];
            logic [PTR_W-1:0]     wr_ptr_reg;
            logic [PTR_W-1:0]     rd_ptr_reg;
            logic [CNT_W-1:0]     count_reg;
            logic                 push;
            logic                 pop;

            // Readiness looks at stored occupancy only, never at this cycle's pop.
            assign full[gi]        = (count_reg == CNT_W'(FIFO_DEPTH));
            assign empty[gi]       = (count_reg == '0);
            assign req_ready_o[gi] = ~full[gi] & ~flush_i;
            assign push            = req_valid_i[gi] & req_ready_o[gi];
            assign pop             = grant[gi];
            assign head_data[gi]   = mem_reg[rd_ptr_reg];

            always_ff @(posedge clk_i or negedge reset_i) begin
                if (!reset_i) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    count_reg  <= '0;
                end else if (flush_i) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    count_reg  <= '0;
                end else begin
                    if (push) begin
                        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
                    end
                    if (pop) begin
                        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
                    end
                    if (push && !pop) begin
                        count_reg <= count_reg + CNT_W'(1);
                    end else if (pop && !push) begin
                        count_reg <= count_reg - CNT_W'(1);
                    end
                end
            end

            always_ff @(posedge clk_i) begin
                if (push) begin
                    mem_reg[wr_ptr_reg] <= req_data_i[gi];
                end
            end
        end
    endgenerate

    // Scan from rr_ptr in circular order; the k-th non-empty FIFO found goes to bus k.
    always_comb begin
        grant          = '0;
        bus_valid_next = '0;
        bus_data_next  = '0;
        bus_src_next   = '0;
        rr_ptr_next    = rr_ptr_reg;
        grant_cnt      = 0;
        for (int j = 0; j < NUM_REQ; j++) begin
            for (int r = 0; r < NUM_REQ; r++) begin
                if ((r == (int'(rr_ptr_reg) + j) % NUM_REQ) && !empty[r] && (grant_cnt < NUM_CDB)) begin
                    grant[r] = 1'b1;
                    for (int k = 0; k < NUM_CDB; k++) begin
                        if (k == grant_cnt) begin
                            bus_valid_next[k] = 1'b1;
                            bus_data_next[k]  = head_data[r];
                            bus_src_next[k]   = SRC_W'(r);
                        end
                    end
                    rr_ptr_next = SRC_W'((r + 1) % NUM_REQ);
                    grant_cnt   = grant_cnt + 1;
                end
            end
        end
        if (flush_i) begin
            grant = '0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            bus_valid_reg <= '0;
            bus_data_reg  <= '0;
            bus_src_reg   <= '0;
            rr_ptr_reg    <= '0;
        end else if (flush_i) begin
            bus_valid_reg <= '0;
            bus_data_reg  <= '0;
            bus_src_reg   <= '0;
            rr_ptr_reg    <= '0;
        end else begin
            bus_valid_reg <= bus_valid_next;
            bus_data_reg  <= bus_data_next;
            bus_src_reg   <= bus_src_next;
            rr_ptr_reg    <= rr_ptr_next;
        end
    end

    assign cdb_valid_o = bus_valid_reg;
    assign cdb_data_o  = bus_data_reg;
    assign cdb_src_o   = bus_src_reg;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed stimulus, per-FU expected-result queues drained
// by an independent bus monitor that also models occupancy, readiness and fairness.
module tb_cdb_arbiter;

    logic                 clk_i = 1'b0;
    logic                 reset_i = 1'b0;
    logic [3:0]           req_valid_i = '0;
    logic [3:0][15:0]     req_data_i = '0;
    logic [3:0]           req_ready_o;
    logic                 flush_i = 1'b0;
    logic [1:0]           cdb_valid_o;
    logic [1:0][15:0]     cdb_data_o;
    logic [1:0][1:0]      cdb_src_o;

    always #5 clk_i = ~clk_i;

    cdb_arbiter #(
        .NUM_REQ    (4),
        .NUM_CDB    (2),
        .CDB_WIDTH  (16),
        .FIFO_DEPTH (2)
    ) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .req_valid_i (req_valid_i),
        .req_data_i  (req_data_i),
        .req_ready_o (req_ready_o),
        .flush_i     (flush_i),
        .cdb_valid_o (cdb_valid_o),
        .cdb_data_o  (cdb_data_o),
        .cdb_src_o   (cdb_src_o)
    );

    int          n_checks = 0;
    int          n_fail = 0;
    logic [15:0] exp_q [4][$];
    int          occ [4];
    int          wait_cnt [4];
    int          sent [4];
    int          base [4];
    logic [3:0]  pend_push = '0;
    logic        pend_flush = 1'b0;
    logic        mon_en = 1'b0;

    logic [3:0]  m_deliv;
    logic [3:0]  m_rdy;
    logic [1:0]  m_expv;
    int          m_ncand;
    int          m_s;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, expv, $time);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 4; i++) begin
            exp_q[i].delete();
            occ[i] = 0;
            wait_cnt[i] = 0;
        end
        pend_push  = '0;
        pend_flush = 1'b0;
    endtask

    function automatic logic [3:0][15:0] seq_data();
        logic [3:0][15:0] d;
        for (int i = 0; i < 4; i++) begin
            d[i] = {4'(i), 12'(sent[i])};
        end
        return d;
    endfunction

    // One clock of stimulus; the expected result is queued once the push is known to be accepted.
    task automatic drive(input logic [3:0] v, input logic [3:0][15:0] d, input logic fl);
        logic [3:0] acc;
        req_valid_i = v;
        req_data_i  = d;
        flush_i     = fl;
        @(negedge clk_i);
        #2;
        acc = v & req_ready_o & {4{~fl}};
        for (int i = 0; i < 4; i++) begin
            if (acc[i]) begin
                exp_q[i].push_back(d[i]);
                sent[i]++;
            end
        end
        pend_push  = acc;
        pend_flush = fl;
        @(posedge clk_i);
        #1;
        req_valid_i = '0;
        flush_i     = 1'b0;
    endtask

    always @(negedge clk_i) begin
        if (mon_en) begin
            m_deliv = '0;
            if (pend_flush) begin
                for (int i = 0; i < 4; i++) begin
                    exp_q[i].delete();
                    occ[i] = 0;
                    wait_cnt[i] = 0;
                end
            end
            m_ncand = 0;
            for (int i = 0; i < 4; i++) begin
                if (occ[i] > 0) m_ncand++;
            end
            m_expv = (pend_flush || m_ncand == 0) ? 2'b00 : ((m_ncand == 1) ? 2'b01 : 2'b11);
            check("bus valid pattern", cdb_valid_o, m_expv);
            for (int k = 0; k < 2; k++) begin
                if (cdb_valid_o[k]) begin
                    m_s = int'(cdb_src_o[k]);
                    if (exp_q[m_s].size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected result: bus%0d src %0d data 0x%0h, expected no result at t=%0t",
                                 k, m_s, cdb_data_o[k], $time);
                    end else begin
                        check($sformatf("bus%0d data fu%0d", k, m_s), cdb_data_o[k], exp_q[m_s].pop_front());
                        m_deliv[m_s] = 1'b1;
                    end
                end else begin
                    check($sformatf("bus%0d idle zero", k), {cdb_data_o[k], cdb_src_o[k]}, '0);
                end
            end
            if (!pend_flush) begin
                for (int i = 0; i < 4; i++) begin
                    if (occ[i] > 0 && !m_deliv[i]) begin
                        wait_cnt[i]++;
                        check($sformatf("fairness fu%0d wait<=1", i), (wait_cnt[i] <= 1), 1);
                    end else begin
                        wait_cnt[i] = 0;
                    end
                end
            end
            for (int i = 0; i < 4; i++) begin
                occ[i] = occ[i] - int'(m_deliv[i]) + int'(pend_push[i]);
                if (occ[i] < 0) occ[i] = 0;
                m_rdy[i] = (occ[i] < 2) && !flush_i;
            end
            check("req_ready", req_ready_o, m_rdy);
            pend_push  = '0;
            pend_flush = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0][15:0] d;
        logic [3:0]       v;
        logic             saw_full0;
        logic             done;
        for (int i = 0; i < 4; i++) sent[i] = 0;
        clear_model();

        // Reset held with random inputs
        repeat (4) begin
            @(posedge clk_i);
            #1;
            req_valid_i = 4'($urandom());
            req_data_i  = {$urandom(), $urandom()};
            #2;
            check("reset cdb_valid", cdb_valid_o, 2'b00);
            check("reset cdb_data", cdb_data_o, '0);
            check("reset cdb_src", cdb_src_o, '0);
            check("reset req_ready", req_ready_o, 4'b1111);
        end
        @(posedge clk_i);
        #1;
        reset_i     = 1'b1;
        req_valid_i = '0;
        req_data_i  = '0;
        mon_en      = 1'b1;
        repeat (3) begin
            drive(4'b0000, '0, 1'b0);
            #3 check("idle after reset", cdb_valid_o, 2'b00);
        end

        // Full contention from rr_ptr = 0
        d = {16'hD003, 16'hD002, 16'hD001, 16'hD000};
        drive(4'b1111, d, 1'b0);
        #3 check("contention cycle1 valid", cdb_valid_o, 2'b00);
        drive(4'b0000, '0, 1'b0);
        #3 check("contention cycle2 valid", cdb_valid_o, 2'b11);
        check("contention cycle2 src", cdb_src_o, {2'd1, 2'd0});
        check("contention cycle2 data", cdb_data_o, {16'hD001, 16'hD000});
        drive(4'b0000, '0, 1'b0);
        #3 check("contention cycle3 valid", cdb_valid_o, 2'b11);
        check("contention cycle3 src", cdb_src_o, {2'd3, 2'd2});
        check("contention cycle3 data", cdb_data_o, {16'hD003, 16'hD002});
        drive(4'b0000, '0, 1'b0);
        #3 check("contention cycle4 valid", cdb_valid_o, 2'b00);

        // rr_ptr back at 0: FU0 must precede FU3
        d = '0;
        d[0] = 16'hE000;
        d[3] = 16'hE003;
        drive(4'b1001, d, 1'b0);
        drive(4'b0000, '0, 1'b0);
        #3 check("rr probe src", cdb_src_o, {2'd3, 2'd0});
        check("rr probe valid", cdb_valid_o, 2'b11);
        drive(4'b0000, '0, 1'b0);

        // Single result, 2-cycle latency
        d = '0;
        d[2] = 16'hABCD;
        drive(4'b0100, d, 1'b0);
        #3 check("single cycle1 valid", cdb_valid_o, 2'b00);
        drive(4'b0000, '0, 1'b0);
        #3 check("single cycle2 valid", cdb_valid_o, 2'b01);
        check("single cycle2 data", cdb_data_o[0], 16'hABCD);
        check("single cycle2 src", cdb_src_o[0], 2'd2);
        drive(4'b0000, '0, 1'b0);
        #3 check("single cycle3 valid", cdb_valid_o, 2'b00);

        // Backpressure: everyone busy every cycle
        saw_full0 = 1'b0;
        repeat (10) begin
            drive(4'b1111, seq_data(), 1'b0);
            if (!req_ready_o[0]) saw_full0 = 1'b1;
        end
        check("fifo0 backpressure seen", saw_full0, 1'b1);
        repeat (6) drive(4'b0000, '0, 1'b0);
        for (int i = 0; i < 4; i++) check($sformatf("backpressure drain fu%0d", i), exp_q[i].size(), 0);

        // Flush with three FIFOs occupied; FU3 pushes during the flush cycle
        drive(4'b0111, seq_data(), 1'b0);
        d = '0;
        d[3] = 16'hDEAD;
        drive(4'b1000, d, 1'b1);
        #3 check("post-flush valid", cdb_valid_o, 2'b00);
        check("post-flush req_ready", req_ready_o, 4'b1111);
        repeat (4) drive(4'b0000, '0, 1'b0);

        // Wrap: 20 results per FU with irregular valid patterns
        for (int i = 0; i < 4; i++) base[i] = sent[i];
        done = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            v = '0;
            done = 1'b1;
            for (int i = 0; i < 4; i++) begin
                if (sent[i] - base[i] < 20) begin
                    done = 1'b0;
                    v[i] = 1'($urandom_range(0, 1));
                end
            end
            if (done) break;
            drive(v, seq_data(), 1'b0);
        end
        check("wrap all pushed", done, 1'b1);
        repeat (6) drive(4'b0000, '0, 1'b0);
        for (int i = 0; i < 4; i++) check($sformatf("wrap drain fu%0d", i), exp_q[i].size(), 0);

        // Asynchronous reset in the middle of traffic
        drive(4'b1111, seq_data(), 1'b0);
        drive(4'b1111, seq_data(), 1'b0);
        mon_en = 1'b0;
        req_valid_i = '0;
        #1 reset_i = 1'b0;
        #1;
        check("mid reset cdb_valid", cdb_valid_o, 2'b00);
        check("mid reset cdb_data", cdb_data_o, '0);
        check("mid reset cdb_src", cdb_src_o, '0);
        check("mid reset req_ready", req_ready_o, 4'b1111);
        @(posedge clk_i);
        #1;
        clear_model();
        reset_i = 1'b1;
        mon_en  = 1'b1;
        repeat (4) begin
            drive(4'b0000, '0, 1'b0);
            #3 check("idle after mid reset", cdb_valid_o, 2'b00);
        end

        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Arbitrates functional-unit results onto the limited set of common data buses that feed the reorder buffer's write-back ports and the reservation stations. Each functional unit pushes finished results through a valid/ready handshake into a private small FIFO. A round-robin scheduler grants up to NUM_CDB FIFO heads per cycle onto registered CDB outputs. A misprediction flush from the reorder buffer discards all buffered and in-flight results.

## Interface
- NUM_REQ, 4: number of requesting functional units.
- NUM_CDB, 2: number of common data buses driven; 1 ≤ NUM_CDB ≤ NUM_REQ.
- CDB_WIDTH, package value: width of one CDB payload word, treated as opaque data.
- FIFO_DEPTH, 2: entries per requester FIFO; power of two, ≥ 2.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- reset_i  input  1  asynchronous, active-low reset.
- req_valid_i  input  NUM_REQ  per-FU result valid.
- req_data_i  input  NUM_REQ x CDB_WIDTH  per-FU result payload.
- req_ready_o  output  NUM_REQ  per-FU FIFO can accept.
- flush_i  input  1  reorder-buffer mispredict; flush everything.
- cdb_valid_o  output  NUM_CDB  bus carries a result this cycle.
- cdb_data_o  output  NUM_CDB x CDB_WIDTH  bus payload; all-zero when the bus is invalid.
- cdb_src_o  output  NUM_CDB x clog2(NUM_REQ)  index of the granted FU; zero when invalid.

## Operation
- Enqueue:
  - req_ready_o[i] = ~full[i] & ~flush_i. It depends on current occupancy only; a same-cycle pop does not free a slot for a same-cycle push.
  - A push to FIFO i occurs when req_valid_i[i] & req_ready_o[i].
- FIFO:
  - Circular buffer with a write pointer, a read pointer and a count of clog2(FIFO_DEPTH)+1 bits.
  - Pointers wrap modulo FIFO_DEPTH.
  - There is no bypass: a pushed entry becomes a head candidate on the following cycle.
- Arbitration, combinational, each cycle:
  - A requester is a candidate if its FIFO is non-empty.
  - Scan indices rr_ptr, rr_ptr+1, …, wrapping modulo NUM_REQ, and grant the first min(NUM_CDB, #candidates) candidates.
  - The k-th grant, in scan order, is assigned to bus k.
  - Each granted FIFO pops its head.
- Pointer update: if any grant occurred, rr_ptr ← (index of last granted requester + 1) mod NUM_REQ; otherwise rr_ptr is unchanged.
- Output register:
  - Each bus k registers valid, data and src from its grant.
  - Ungranted buses register valid=0, data=0, src=0.
- Fairness: with all FIFOs continuously non-empty, any head waits at most ceil(NUM_REQ/NUM_CDB)−1 cycles before a grant.
- Flush (flush_i=1), applied at the next edge:
  - All FIFO counts and pointers clear to 0.
  - All output registers clear.
  - rr_ptr clears to 0.
  - No grants or pushes take effect that cycle.
  - Results presented during the flush cycle are dropped.
- Reset (reset_i=0), taking effect immediately regardless of clock:
  - All FIFOs empty; rr_ptr=0.
  - cdb_valid_o=0, cdb_data_o=0, cdb_src_o=0.
  - req_ready_o is all-ones whenever reset_i=0 and flush_i=0; the FIFOs are empty.
- Reset asserted mid-operation discards all buffered results with no partial outputs.

## Timing
- Push at edge t → head candidate during cycle t+1 → granted result on cdb_*_o during cycle t+2. Minimum latency is 2 cycles.
- Under contention, latency is 2 + wait cycles.
- Outputs are driven purely from flops.
- req_ready_o is combinational from occupancy and flush_i only; it never depends on req_valid_i.
- A full FIFO that pops at edge t raises req_ready_o in cycle t+1.
- A simultaneous push and pop on a non-full FIFO leaves count unchanged.
- flush_i and grants in the same cycle: flush wins, and cdb_valid_o is 0 in the following cycle.
- Sustained throughput is NUM_CDB results per cycle when at least NUM_CDB FIFOs are non-empty.

## Test plan
- Reset: hold reset_i=0 with random inputs → all cdb_*_o = 0 and req_ready_o = 4'b1111. After release, with no requests, cdb_valid_o stays 2'b00.
- Single result: FU2 pushes data 0xABCD at edge 0 → cdb_valid_o=2'b01, cdb_data_o[0]=0xABCD, cdb_src_o[0]=2 during cycle 2. The bus is invalid in cycles 1 and 3.
- Full contention: all 4 FUs push one result at the same edge → cycle 2 carries src {0,1} on buses {0,1}; cycle 3 carries {2,3}; rr_ptr ends at 0.
- Backpressure: FU0 pushes every cycle while FUs 1–3 also stay busy → FIFO0 reaches 2 entries and req_ready_o[0]=0. No data is lost or duplicated; the scoreboard shows in-order delivery per FU.
- Flush: 3 FIFOs hold entries and flush_i pulses for one cycle → the next cycle has cdb_valid_o=0 and req_ready_o=4'b1111. A push made during the flush cycle never appears on the buses.
- Wrap: stream 20 results per FU with random valid patterns → each FU's FIFO pointers wrap several times. Per-FU order is preserved, and the fairness bound holds on every cycle.
